// File: rtl/mem_if.sv
// Bus bundle between a strobe-driven initiator and the mem_responder.
interface mem_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic              prot_err;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output read, write, addr, data_in,
        input  data_out, ready, prot_err, rd_count, wr_count
    );

    modport slave (
        input  read, write, addr, data_in,
        output data_out, ready, prot_err, rd_count, wr_count
    );
endinterface

// File: rtl/mem_responder.sv
// Word memory responder with programmable wait states, 4-phase ready handshake,
// sticky protocol-error flag and saturating access counters.
module mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 16
) (
    input  logic  clk,
    input  logic  rst,
    mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              op_wr, op_wr_nxt;
    logic [ADDR_W-1:0] addr_l, addr_l_nxt;
    logic [DATA_W-1:0] data_l, data_l_nxt;
    logic [DATA_W-1:0] dout_q, dout_nxt;
    logic              ready_q, ready_nxt;
    logic              perr_q, perr_nxt;
    logic [CNT_W-1:0]  rd_q, rd_nxt;
    logic [CNT_W-1:0]  wr_q, wr_nxt;
    logic              mem_we;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_wr_nxt  = op_wr;
        addr_l_nxt = addr_l;
        data_l_nxt = data_l;
        dout_nxt   = dout_q;
        ready_nxt  = ready_q;
        perr_nxt   = perr_q;
        rd_nxt     = rd_q;
        wr_nxt     = wr_q;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.read && bus.write) begin
                    perr_nxt = 1'b1;
                end else if (bus.read || bus.write) begin
                    op_wr_nxt  = bus.write;
                    addr_l_nxt = bus.addr;
                    data_l_nxt = bus.data_in;
                    cnt_nxt    = 4'(WAIT_STATES);
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                // Initiator must hold exactly its own strobe for the whole wait.
                if (op_wr ? (!bus.write || bus.read) : (!bus.read || bus.write)) begin
                    perr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (op_wr) begin
                        mem_we = 1'b1;
                        wr_nxt = sat_inc(wr_q);
                    end else begin
                        dout_nxt = mem[addr_l];
                        rd_nxt   = sat_inc(rd_q);
                    end
                    ready_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!bus.read && !bus.write) begin
                    ready_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dout_q  <= dout_nxt;
            ready_q <= ready_nxt;
            perr_q  <= perr_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
        end
    end

    // Request latches and storage carry no reset; they are only consumed after acceptance.
    always_ff @(posedge clk) begin
        op_wr  <= op_wr_nxt;
        addr_l <= addr_l_nxt;
        data_l <= data_l_nxt;
        if (mem_we) begin
            mem[addr_l] <= data_l;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.ready    = ready_q;
    assign bus.prot_err = perr_q;
    assign bus.rd_count = rd_q;
    assign bus.wr_count = wr_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a queue scoreboard holds expected read data.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) a_if ();
    mem_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(2))  b_if ();

    mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    int         total = 0;
    int         bad   = 0;
    int         exp_rd = 0;
    int         exp_wr = 0;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] ref_mem [32];
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        last_rd = 8'h00;
    endtask

    task automatic a_access(input bit wr, input logic [4:0] ad, input logic [7:0] d);
        int n;
        @(negedge clk);
        a_if.write   = wr;
        a_if.read    = !wr;
        a_if.addr    = ad;
        a_if.data_in = d;
        if (wr) ref_mem[ad] = d;
        else exp_q.push_back(ref_mem[ad]);
        @(negedge clk);
        a_if.addr    = ~ad;
        a_if.data_in = ~d;
        n = 0;
        while (a_if.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(wr ? "wr_ready" : "rd_ready", 32'(a_if.ready), 32'd1);
        if (wr) begin
            exp_wr++;
            chk("dout_hold", 32'(a_if.data_out), 32'(last_rd));
        end else begin
            exp_rd++;
            last_rd = exp_q.pop_front();
            chk("rd_data", 32'(a_if.data_out), 32'(last_rd));
        end
        a_if.write = 1'b0;
        a_if.read  = 1'b0;
        @(negedge clk);
        chk("ready_drop", 32'(a_if.ready), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        bit         seen;
        int         n;
        a_if.read = 1'b0; a_if.write = 1'b0; a_if.addr = '0; a_if.data_in = '0;
        b_if.read = 1'b0; b_if.write = 1'b0; b_if.addr = '0; b_if.data_in = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(a_if.ready), 32'd0);
        chk("rst_dout", 32'(a_if.data_out), 32'd0);
        chk("rst_perr", 32'(a_if.prot_err), 32'd0);
        chk("rst_rdcnt", 32'(a_if.rd_count), 32'd0);
        chk("rst_wrcnt", 32'(a_if.wr_count), 32'd0);
        chk("rst_b_ready", 32'(b_if.ready), 32'd0);
        rst = 1'b0;

        // Fill and read back the whole array.
        for (int a = 0; a < 32; a++) begin
            v = 8'(8'h41 + a % 26);
            a_access(1'b1, 5'(a), v);
        end
        for (int a = 0; a < 32; a++) a_access(1'b0, 5'(a), 8'h00);
        chk("fill_wrcnt", 32'(a_if.wr_count), 32'(exp_wr));
        chk("fill_rdcnt", 32'(a_if.rd_count), 32'(exp_rd));
        chk("fill_perr", 32'(a_if.prot_err), 32'd0);

        // Cycle-exact handshake timing.
        @(negedge clk);
        a_if.write = 1'b1; a_if.addr = 5'd10; a_if.data_in = 8'h99;
        ref_mem[10] = 8'h99;
        @(negedge clk);
        chk("lat_e0", 32'(a_if.ready), 32'd0);
        @(negedge clk);
        chk("lat_e1", 32'(a_if.ready), 32'd0);
        @(negedge clk);
        chk("lat_e2", 32'(a_if.ready), 32'd0);
        @(negedge clk);
        chk("lat_e3", 32'(a_if.ready), 32'd1);
        a_if.write = 1'b0;
        @(negedge clk);
        chk("lat_drop", 32'(a_if.ready), 32'd0);
        exp_wr++;
        chk("lat_wrcnt", 32'(a_if.wr_count), 32'(exp_wr));
        a_access(1'b0, 5'd10, 8'h00);

        // Both strobes together in IDLE.
        @(negedge clk);
        a_if.read = 1'b1; a_if.write = 1'b1; a_if.addr = 5'd5; a_if.data_in = 8'hEE;
        repeat (3) @(negedge clk);
        chk("both_perr", 32'(a_if.prot_err), 32'd1);
        chk("both_ready", 32'(a_if.ready), 32'd0);
        chk("both_rdcnt", 32'(a_if.rd_count), 32'(exp_rd));
        chk("both_wrcnt", 32'(a_if.wr_count), 32'(exp_wr));
        a_if.read = 1'b0; a_if.write = 1'b0;
        a_access(1'b0, 5'd5, 8'h00);
        chk("both_perr_sticky", 32'(a_if.prot_err), 32'd1);

        do_reset();
        chk("rst2_perr", 32'(a_if.prot_err), 32'd0);
        chk("rst2_wrcnt", 32'(a_if.wr_count), 32'd0);

        // Strobe dropped one cycle after acceptance.
        @(negedge clk);
        a_if.write = 1'b1; a_if.addr = 5'd7; a_if.data_in = 8'h5A;
        @(negedge clk);
        a_if.write = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_if.ready === 1'b1) seen = 1'b1;
        end
        chk("abort_ready_seen", 32'(seen), 32'd0);
        chk("abort_perr", 32'(a_if.prot_err), 32'd1);
        chk("abort_wrcnt", 32'(a_if.wr_count), 32'd0);
        a_access(1'b0, 5'd7, 8'h00);

        // Asynchronous reset while a write is waiting.
        @(negedge clk);
        a_if.write = 1'b1; a_if.addr = 5'd3; a_if.data_in = 8'h7A;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", 32'(a_if.ready), 32'd0);
        chk("async_dout", 32'(a_if.data_out), 32'd0);
        chk("async_perr", 32'(a_if.prot_err), 32'd0);
        chk("async_rdcnt", 32'(a_if.rd_count), 32'd0);
        repeat (4) @(negedge clk);
        a_if.write = 1'b0;
        rst = 1'b0;
        exp_rd = 0; exp_wr = 0; last_rd = 8'h00;
        a_access(1'b0, 5'd3, 8'h00);
        chk("async_rdcnt_after", 32'(a_if.rd_count), 32'd1);
        chk("async_wrcnt_after", 32'(a_if.wr_count), 32'd0);

        // Zero wait states and counter saturation on the narrow-counter instance.
        @(negedge clk);
        b_if.write = 1'b1; b_if.addr = 5'd1; b_if.data_in = 8'h33;
        @(negedge clk);
        chk("b_lat_e0", 32'(b_if.ready), 32'd0);
        @(negedge clk);
        chk("b_lat_e1", 32'(b_if.ready), 32'd1);
        chk("b_wrcnt", 32'(b_if.wr_count), 32'd1);
        b_if.write = 1'b0;
        @(negedge clk);
        chk("b_drop", 32'(b_if.ready), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            b_if.read = 1'b1; b_if.addr = 5'd1;
            exp_q.push_back(8'h33);
            n = 0;
            @(negedge clk);
            while (b_if.ready !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("b_rd_data", 32'(b_if.data_out), 32'(exp_q.pop_front()));
            chk("b_rdcnt_sat", 32'(b_if.rd_count), 32'((i > 3) ? 3 : i));
            b_if.read = 1'b0;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
